fifomult_param: RTL and testbench

Parametrised successor of the fifomult2024 operand-pair multiplier. It accepts a serial stream of operands, each with a parity bit, and buffers them in a DEPTH-entry FIFO. Consecutive words are paired as A then B, and the block emits one 2*DATA_W product per pair. New relative to the 2024 block:
- configurable width, depth and signedness
- valid/ready backpressure on the output
- sticky overflow flag
- FIFO level visibility
It sits between the serial operand source and the result consumer in the fifomult test environment.

---
 rtl/fifomult_if.sv | 34 +++
 rtl/fifomult_param.sv | 138 +++++++++++++
 tb/tb_fifomult_param.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifomult_if.sv
// Operand/result bus for the fifomult pair multiplier.
//   master : operand source and result consumer (drives data_in*, data_out_ready)
//   slave  : the multiplier (drives busy, result, status and level)
// DATA_W : operand width; DEPTH : FIFO depth, sizes fifo_level.
interface fifomult_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   data_in;
    logic                data_in_parity;
    logic                data_in_valid;
    logic                busy_out;
    logic [2*DATA_W-1:0] data_out;
    logic                data_out_parity;
    logic                data_out_valid;
    logic                data_out_ready;
    logic                data_out_error;
    logic                overflow;
    logic [LVL_W-1:0]    fifo_level;

    modport master (
        output data_in, data_in_parity, data_in_valid, data_out_ready,
        input  busy_out, data_out, data_out_parity, data_out_valid,
               data_out_error, overflow, fifo_level
    );

    modport slave (
        input  data_in, data_in_parity, data_in_valid, data_out_ready,
        output busy_out, data_out, data_out_parity, data_out_valid,
               data_out_error, overflow, fifo_level
    );
endinterface

// File: rtl/fifomult_param.sv
// fifomult_param: buffers a serial operand stream in a DEPTH-entry FIFO,
// pops words two at a time (A then B) and registers their full-width
// product with a valid/ready output handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fifomult_if slave -- operand input with parity, busy, result
//           with parity/error, sticky overflow and FIFO level
module fifomult_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    fifomult_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RES_W = 2 * DATA_W;

    typedef struct packed {
        logic              perr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_b_ptr;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [RES_W-1:0]   dout_q, dout_d;
    logic               par_q, par_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic               push, pop;
    entry_t             op_a, op_b;
    logic [RES_W-1:0]   a_ext, b_ext, prod;

    assign push = bus.data_in_valid && !busy_q;
    assign pop  = (level_q >= LVL_W'(2)) && (!vld_q || bus.data_out_ready);

    assign wr_entry.perr = bus.data_in_parity != (^bus.data_in);
    assign wr_entry.data = bus.data_in;

    // The read pointer only ever moves in steps of two from zero, so it is
    // always even and B sits at the same address with the LSB set.
    assign rd_b_ptr = rd_ptr_q | PTR_W'(1);
    assign op_a     = mem_q[rd_ptr_q];
    assign op_b     = mem_q[rd_b_ptr];

    // Extending both operands to the result width makes a plain modular
    // multiply give the exact signed or unsigned product.
    assign a_ext = SIGNED ? {{DATA_W{op_a.data[DATA_W-1]}}, op_a.data}
                          : {{DATA_W{1'b0}}, op_a.data};
    assign b_ext = SIGNED ? {{DATA_W{op_b.data[DATA_W-1]}}, op_b.data}
                          : {{DATA_W{1'b0}}, op_b.data};
    assign prod  = a_ext * b_ext;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        par_d    = par_q;
        vld_d    = vld_q;
        err_d    = err_q;

        if (push)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 2)) ? '0 : rd_ptr_q + PTR_W'(2);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(2);
            2'b11:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Dropped writes latch overflow even when a pop frees space this cycle.
        ovf_d  = ovf_q || (bus.data_in_valid && busy_q);
        busy_d = (level_d == LVL_W'(DEPTH));

        if (pop) begin
            err_d  = op_a.perr || op_b.perr;
            dout_d = err_d ? '0 : prod;
            par_d  = ^dout_d;
            vld_d  = 1'b1;
        end else if (vld_q && bus.data_out_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            par_q    <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            par_q    <= par_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: entries are only read once the level says
    // they were written since the last reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    assign bus.busy_out        = busy_q;
    assign bus.overflow        = ovf_q;
    assign bus.fifo_level      = level_q;
    assign bus.data_out        = dout_q;
    assign bus.data_out_parity = par_q;
    assign bus.data_out_valid  = vld_q;
    assign bus.data_out_error  = err_q;
endmodule

// File: tb/tb_fifomult_param.sv
// Self-checking bench for fifomult_param: a signed DEPTH=8 instance driven
// through a scoreboard, plus an unsigned instance checked directly.
module tb_fifomult_param;
    localparam int W = 16;
    localparam int D = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifomult_if #(.DATA_W(W), .DEPTH(D)) sb ();
    fifomult_if #(.DATA_W(W), .DEPTH(D)) ub ();

    fifomult_param #(.DATA_W(W), .DEPTH(D), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sb));
    fifomult_param #(.DATA_W(W), .DEPTH(D), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(ub));

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t mon_e;
    logic have_a = 1'b0;
    logic [15:0] a_w;
    logic a_bad;

    function automatic res_t model_s(logic [15:0] a, logic [15:0] b, logic ea, logic eb);
        res_t r;
        logic signed [31:0] p;
        p      = $signed(a) * $signed(b);
        r.err  = ea | eb;
        r.data = r.err ? 32'h0 : p;
        return r;
    endfunction

    task automatic note_word(input logic [15:0] d, input logic bad);
        if (!have_a) begin
            a_w = d; a_bad = bad; have_a = 1'b1;
        end else begin
            exp_q.push_back(model_s(a_w, d, a_bad, bad));
            have_a = 1'b0;
        end
    endtask

    // One write cycle on the signed instance; only accepted words enter the model.
    task automatic push_s(input logic [15:0] d, input logic bad);
        logic acc;
        acc = !sb.busy_out;
        sb.data_in = d;
        sb.data_in_parity = (^d) ^ bad;
        sb.data_in_valid = 1'b1;
        @(posedge clk); #1;
        sb.data_in_valid = 1'b0;
        if (acc) note_word(d, bad);
    endtask

    task automatic wait_empty(output bit ok);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        ok = (exp_q.size() == 0);
    endtask

    // Scoreboard consumer: every handshake on the signed instance pops one result.
    always @(negedge clk) begin
        if (rst_n && sb.data_out_valid && sb.data_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got err=%b data=%h, required no result",
                         sb.data_out_error, sb.data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({sb.data_out_error, sb.data_out, sb.data_out_parity} !==
                    {mon_e.err, mon_e.data, ^mon_e.data}) begin
                    errors++;
                    $display("FAIL sb_result: got err=%b data=%h par=%b, required err=%b data=%h par=%b",
                             sb.data_out_error, sb.data_out, sb.data_out_parity,
                             mon_e.err, mon_e.data, ^mon_e.data);
                end
            end
        end
    end

    task automatic test_reset;
        sb.data_in = '0; sb.data_in_parity = 1'b0; sb.data_in_valid = 1'b0; sb.data_out_ready = 1'b1;
        ub.data_in = '0; ub.data_in_parity = 1'b0; ub.data_in_valid = 1'b0; ub.data_out_ready = 1'b1;
        #1;
        checks++;
        if ({sb.fifo_level, sb.busy_out, sb.overflow, sb.data_out, sb.data_out_parity,
             sb.data_out_valid, sb.data_out_error} !== 41'h0) begin
            errors++;
            $display("FAIL reset_state: got lvl=%0d busy=%b ovf=%b data=%h par=%b vld=%b err=%b, required all 0",
                     sb.fifo_level, sb.busy_out, sb.overflow, sb.data_out, sb.data_out_parity,
                     sb.data_out_valid, sb.data_out_error);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_signed;
        bit ok;
        push_s(16'h7FFF, 1'b0);
        push_s(16'h7FFF, 1'b0);
        checks++;
        if (sb.data_out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: got vld=%b, required 0", sb.data_out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({sb.data_out_valid, sb.data_out} !== {1'b1, 32'h3FFF0001}) begin
            errors++;
            $display("FAIL signed_max: got vld=%b data=%h, required vld=1 data=3fff0001",
                     sb.data_out_valid, sb.data_out);
        end
        push_s(16'hFFFF, 1'b0);
        push_s(16'h8000, 1'b0);
        wait_empty(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL signed_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic u_pair(input logic [15:0] a, input logic [15:0] b);
        ub.data_in = a; ub.data_in_parity = ^a; ub.data_in_valid = 1'b1;
        @(posedge clk); #1;
        ub.data_in = b; ub.data_in_parity = ^b;
        @(posedge clk); #1;
        ub.data_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        u_pair(16'hFFFF, 16'hFFFF);
        checks++;
        if ({ub.data_out_valid, ub.data_out_error, ub.data_out, ub.data_out_parity} !==
            {1'b1, 1'b0, 32'hFFFE0001, ^32'hFFFE0001}) begin
            errors++;
            $display("FAIL unsigned_max: got vld=%b err=%b data=%h par=%b, required vld=1 err=0 data=fffe0001 par=%b",
                     ub.data_out_valid, ub.data_out_error, ub.data_out, ub.data_out_parity, ^32'hFFFE0001);
        end
        u_pair(16'h0000, 16'h8000);
        checks++;
        if ({ub.data_out_valid, ub.data_out_error, ub.data_out} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL unsigned_zero: got vld=%b err=%b data=%h, required vld=1 err=0 data=0",
                     ub.data_out_valid, ub.data_out_error, ub.data_out);
        end
    endtask

    task automatic test_parity;
        bit ok;
        push_s(16'h0001, 1'b1);
        push_s(16'h0003, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({sb.data_out_valid, sb.data_out_error, sb.data_out, sb.data_out_parity} !==
            {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL parity_err: got vld=%b err=%b data=%h par=%b, required vld=1 err=1 data=0 par=0",
                     sb.data_out_valid, sb.data_out_error, sb.data_out, sb.data_out_parity);
        end
        push_s(16'h0002, 1'b0);
        push_s(16'h0003, 1'b0);
        wait_empty(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL parity_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        bit ok;
        sb.data_out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) push_s(16'(i), 1'b0);
        checks++;
        if ({sb.fifo_level, sb.busy_out, sb.data_out_valid, sb.data_out, sb.overflow} !==
            {4'd8, 1'b1, 1'b1, 32'd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_full: got lvl=%0d busy=%b vld=%b data=%h ovf=%b, required lvl=8 busy=1 vld=1 data=2 ovf=0",
                     sb.fifo_level, sb.busy_out, sb.data_out_valid, sb.data_out, sb.overflow);
        end
        push_s(16'd11, 1'b0);
        checks++;
        if ({sb.overflow, sb.fifo_level} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL bp_overflow: got ovf=%b lvl=%0d, required ovf=1 lvl=8", sb.overflow, sb.fifo_level);
        end
        held = sb.data_out;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sb.data_out_valid, sb.data_out, sb.data_out_error} !== {1'b1, 32'd2, 1'b0} || sb.data_out !== held) begin
            errors++;
            $display("FAIL bp_hold: got vld=%b data=%h err=%b, required vld=1 data=2 err=0",
                     sb.data_out_valid, sb.data_out, sb.data_out_error);
        end
        sb.data_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sb.busy_out, sb.data_out_valid, sb.fifo_level} !== {1'b0, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL bp_release: got busy=%b vld=%b lvl=%0d, required busy=0 vld=1 lvl=6",
                     sb.busy_out, sb.data_out_valid, sb.fifo_level);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (sb.data_out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_stream%0d: got vld=%b, required 1", k, sb.data_out_valid);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({sb.data_out_valid, sb.fifo_level, sb.overflow} !== {1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL bp_end: got vld=%b lvl=%0d ovf=%b, required vld=0 lvl=0 ovf=1",
                     sb.data_out_valid, sb.fifo_level, sb.overflow);
        end
        wait_empty(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        push_s(16'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sb.fifo_level, sb.busy_out, sb.overflow, sb.data_out, sb.data_out_parity,
             sb.data_out_valid, sb.data_out_error} !== 41'h0) begin
            errors++;
            $display("FAIL reset_mid_state: got lvl=%0d busy=%b ovf=%b data=%h vld=%b err=%b, required all 0",
                     sb.fifo_level, sb.busy_out, sb.overflow, sb.data_out, sb.data_out_valid, sb.data_out_error);
        end
        exp_q.delete();
        have_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_s(16'd7, 1'b0);
        push_s(16'd9, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({sb.data_out_valid, sb.data_out} !== {1'b1, 32'd63}) begin
            errors++;
            $display("FAIL reset_mid_result: got vld=%b data=%h, required vld=1 data=3f",
                     sb.data_out_valid, sb.data_out);
        end
        wait_empty(ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ok, sb.data_out_valid, sb.fifo_level} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_mid_single: got drained=%b vld=%b lvl=%0d, required drained=1 vld=0 lvl=0",
                     ok, sb.data_out_valid, sb.fifo_level);
        end
    endtask

    task automatic test_random;
        int words = 0;
        bit ok;
        logic acc, bad;
        logic [15:0] d;
        for (int cyc = 0; cyc < 20000 && words < 200; cyc++) begin
            sb.data_out_ready = 1'($urandom_range(0, 1));
            acc = !sb.busy_out && ($urandom_range(0, 2) != 0);
            d   = 16'($urandom);
            bad = ($urandom_range(0, 15) == 0);
            sb.data_in = d;
            sb.data_in_parity = (^d) ^ bad;
            sb.data_in_valid = acc;
            @(posedge clk); #1;
            if (acc) begin
                note_word(d, bad);
                words++;
            end
        end
        sb.data_in_valid = 1'b0;
        sb.data_out_ready = 1'b1;
        wait_empty(ok);
        checks++;
        if ({ok, sb.overflow} !== 2'b10 || words != 200) begin
            errors++;
            $display("FAIL random_stream: got drained=%b ovf=%b words=%0d, required drained=1 ovf=0 words=200",
                     ok, sb.overflow, words);
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_parity();
        test_backpressure();
        test_reset_mid();
        test_random();
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end
endmodule
